serial_adder: RTL and testbench

- Parametrised multi-cycle adder/subtractor that processes DIGIT bits per clock over WIDTH-bit operands, using a single carry flip-flop between digits.
- Successor to the single-bit gate-level full adder, generalised in width, throughput and mode (add/sub).
- Used as an area-cheap arithmetic unit in lab datapaths; driven by a start/done handshake from a controller FSM.

---
 rtl/adder_pkg.sv | 25 ++
 rtl/digit_adder.sv | 36 +++
 rtl/serial_adder.sv | 124 ++++++++++++
 tb/tb_serial_adder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package adder_pkg;

    // Controller states of the serial adder.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Ceiling log2, used to size the digit step counter.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple-carry adder built from full-adder cells.
// Latency: combinational.
// Backpressure: none; pure function of x, y, ci.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             cm,
`endif
    output logic             co
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    genvar i;
    generate
        for (i = 0; i < DIGIT; i++) begin : g_fa
            assign s[i]   = x[i] ^ y[i] ^ c[i];
            assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    endgenerate

    assign co = c[DIGIT];

`ifdef SERIAL_ADDER_OVF_EN
    // Carry into the top cell; XOR with co gives signed overflow on the last digit.
    assign cm = c[DIGIT-1];
`endif

endmodule

// File: rtl/serial_adder.sv
// Digit-serial WIDTH-bit add/subtract, DIGIT bits per clock through one carry flop; optional ovf output under SERIAL_ADDER_OVF_EN.
// Latency: done pulses in the cycle after the (WIDTH/DIGIT)-th edge following the accepting edge; one op per N+2 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, caller waits for done/!busy.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,   // >= 2
    parameter int DIGIT = 1    // must divide WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (clog2(N) < 1) ? 1 : clog2(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [DIGIT-1:0]       dsum;
    logic                   dco;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_next;
`ifdef SERIAL_ADDER_OVF_EN
    logic                   dcm;
`endif

    // The single adder slice works on the low digit of the operand shifters.
    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .x  (a_sh[DIGIT-1:0]),
        .y  (b_sh[DIGIT-1:0]),
        .ci (carry),
        .s  (dsum),
`ifdef SERIAL_ADDER_OVF_EN
        .cm (dcm),
`endif
        .co (dco)
    );

    // New digit enters the result from the MSB side; works for DIGIT == WIDTH too.
    assign res_cat  = {dsum, res};
    assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];

    // Control FSM plus datapath registers; outputs are registered and held between ops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1; cin is ignored in that mode.
                        a_sh  <= a;
                        b_sh  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    res   <= res_next;
                    carry <= dco;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Visible result only changes here, so sum/cout are stable during RUN.
                        sum   <= res_next;
                        cout  <= dco;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf   <= dcm ^ dco;
`endif
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: 8-bit DIGIT=1/4 vectors, mid-run corner cases, 4-bit exhaustive sweep.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start8, start4, sub, cin;
    logic [7:0] a8, b8;
    logic [3:0] a4, b4;

    logic       busy_d1, done_d1, cout_d1, busy_d4, done_d4, cout_d4;
    logic [7:0] sum_d1, sum_d4;
    logic       busy4 [3];
    logic       done4 [3];
    logic       cout4 [3];
    logic [3:0] sum4  [3];
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf_d1, ovf_d4;
    logic       ovf4 [3];
`endif

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub), .a(a8), .b(b8), .cin(cin),
        .busy(busy_d1), .done(done_d1), .sum(sum_d1),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf_d1),
`endif
        .cout(cout_d1));

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub), .a(a8), .b(b8), .cin(cin),
        .busy(busy_d4), .done(done_d4), .sum(sum_d4),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf_d4),
`endif
        .cout(cout_d4));

    serial_adder #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub), .a(a4), .b(b4), .cin(cin),
        .busy(busy4[0]), .done(done4[0]), .sum(sum4[0]),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf4[0]),
`endif
        .cout(cout4[0]));

    serial_adder #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub), .a(a4), .b(b4), .cin(cin),
        .busy(busy4[1]), .done(done4[1]), .sum(sum4[1]),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf4[1]),
`endif
        .cout(cout4[1]));

    serial_adder #(.WIDTH(4), .DIGIT(4)) u_w4d4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub), .a(a4), .b(b4), .cin(cin),
        .busy(busy4[2]), .done(done4[2]), .sum(sum4[2]),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf4[2]),
`endif
        .cout(cout4[2]));

    typedef struct packed {
        logic       sub;
        logic       cin;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Waits for the DIGIT=1 instance's done pulse; lat = -1 when the budget expires.
    task automatic wait_d1(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (done_d1) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         l1, l4, n, r, sr, sa, sbv, ec, eo, es;
        logic       seen;
        logic [7:0] prev_sum;

        //           sub   cin   a      b      sum    cout  ovf
        vecs[0] = '{1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'h3C, 8'h4D, 8'h8A, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 8'hA5, 8'h5A, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};

        rst = 1'b1; start8 = 1'b0; start4 = 1'b0; sub = 1'b0; cin = 1'b0;
        a8 = 8'h00; b8 = 8'h00; a4 = 4'h0; b4 = 4'h0;
        tick();
        tick();
        chk("rst_busy_d1", busy_d1, 0);
        chk("rst_done_d1", done_d1, 0);
        chk("rst_sum_d1",  sum_d1, 0);
        chk("rst_cout_d1", cout_d1, 0);
        chk("rst_busy_d4", busy_d4, 0);
        chk("rst_sum_d4",  sum_d4, 0);
        rst = 1'b0;
        tick();

        // Table-driven 8-bit vectors on both DIGIT=1 and DIGIT=4 instances.
        prev_sum = 8'h00;
        for (int i = 0; i < 8; i++) begin
            sub = vecs[i].sub; cin = vecs[i].cin; a8 = vecs[i].a; b8 = vecs[i].b;
            start8 = 1'b1;
            tick();
            start8 = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom); cin = ~cin;
            l1 = -1; l4 = -1;
            for (int k = 1; k <= 20; k++) begin
                tick();
                if (k == 1) chk($sformatf("hold_sum_v%0d", i), sum_d1, prev_sum);
                if (done_d1 && l1 < 0) l1 = k;
                if (done_d4 && l4 < 0) l4 = k;
                if (!busy_d1 && !busy_d4) break;
            end
            chk($sformatf("lat_d1_v%0d", i), l1, 8);
            chk($sformatf("lat_d4_v%0d", i), l4, 2);
            chk($sformatf("sum_d1_v%0d", i), sum_d1, vecs[i].sum);
            chk($sformatf("cout_d1_v%0d", i), cout_d1, vecs[i].cout);
            chk($sformatf("sum_d4_v%0d", i), sum_d4, vecs[i].sum);
            chk($sformatf("cout_d4_v%0d", i), cout_d4, vecs[i].cout);
`ifdef SERIAL_ADDER_OVF_EN
            chk($sformatf("ovf_d1_v%0d", i), ovf_d1, vecs[i].ovf);
            chk($sformatf("ovf_d4_v%0d", i), ovf_d4, vecs[i].ovf);
`endif
            prev_sum = vecs[i].sum;
        end

        // start re-pulsed during RUN and operands changed after acceptance.
        sub = 1'b0; cin = 1'b1; a8 = 8'h3C; b8 = 8'h4D; start8 = 1'b1;
        tick();
        a8 = 8'hFF; b8 = 8'hFF; cin = 1'b0; sub = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        chk("midrun_d4_done", done_d4, 1);
        chk("midrun_d4_sum",  sum_d4, 8'h8A);
        chk("midrun_d4_cout", cout_d4, 0);
        tick();
        chk("midrun_d4_pulse", done_d4, 0);
        chk("midrun_d4_idle",  busy_d4, 0);
        wait_d1(l1);
        chk("midrun_d1_lat", (l1 < 0) ? -1 : l1 + 3, 8);
        chk("midrun_d1_sum", sum_d1, 8'h8A);

        // Reset in the third RUN cycle abandons the op.
        sub = 1'b0; cin = 1'b0; a8 = 8'h7F; b8 = 8'h01; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy_d1, 0);
        chk("abort_done", done_d1, 0);
        chk("abort_sum",  sum_d1, 0);
        chk("abort_cout", cout_d1, 0);
        chk("abort_sum_d4", sum_d4, 0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("abort_ovf_d4", ovf_d4, 0);
`endif
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done_d1 || busy_d1) seen = 1'b1;
        end
        chk("abort_no_done", seen, 0);

        // rst and start together: not accepted.
        rst = 1'b1; start8 = 1'b1;
        tick();
        rst = 1'b0; start8 = 1'b0;
        tick();
        chk("rst_start_busy", busy_d1, 0);

        // Normal operation after the abort.
        sub = 1'b1; a8 = 8'h07; b8 = 8'h05; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait_d1(l1);
        chk("post_abort_lat",  l1, 8);
        chk("post_abort_sum",  sum_d1, 8'h02);
        chk("post_abort_cout", cout_d1, 1);

        // Exhaustive 4-bit sweep over DIGIT = 1, 2, 4.
        for (int sb = 0; sb < 2; sb++) begin
            for (int ci = 0; ci < 2; ci++) begin
                for (int a = 0; a < 16; a++) begin
                    for (int b = 0; b < 16; b++) begin
                        sub = sb[0]; cin = ci[0]; a4 = 4'(a); b4 = 4'(b);
                        start4 = 1'b1;
                        tick();
                        start4 = 1'b0;
                        n = 0;
                        while ((busy4[0] || busy4[1] || busy4[2]) && n < 10) begin
                            tick();
                            n++;
                        end
                        if (n >= 10) chk("sweep_timeout", n, 0);
                        sa  = (a >= 8) ? a - 16 : a;
                        sbv = (b >= 8) ? b - 16 : b;
                        if (sb != 0) begin
                            r  = a - b;
                            ec = (a >= b) ? 1 : 0;
                            sr = sa - sbv;
                        end else begin
                            r  = a + b + ci;
                            ec = (r > 15) ? 1 : 0;
                            sr = sa + sbv + ci;
                        end
                        es = r & 15;
                        eo = (sr > 7 || sr < -8) ? 1 : 0;
                        for (int j = 0; j < 3; j++) begin
                            chk($sformatf("sweep_sum_i%0d_s%0d_c%0d_a%0d_b%0d", j, sb, ci, a, b), sum4[j], es);
                            chk($sformatf("sweep_cout_i%0d_s%0d_c%0d_a%0d_b%0d", j, sb, ci, a, b), cout4[j], ec);
`ifdef SERIAL_ADDER_OVF_EN
                            chk($sformatf("sweep_ovf_i%0d_s%0d_c%0d_a%0d_b%0d", j, sb, ci, a, b), ovf4[j], eo);
`endif
                        end
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
